// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALU op codes, FSM encoding and requester ids for the ALU share arbiter
package alu_arb_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_PMP = 1'b1;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, response and ALU-side signals of the ALU share arbiter
interface alu_share_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OP_W-1:0] req_op;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic              req_lock;
  logic [OP_W-1:0]   alu_op;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_result;
  logic              alu_zero;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [XLEN-1:0]   resp_result;
  logic              resp_zero;
  logic              resp_err;

  // master = requesters plus ALU instance; slave = the arbiter
  modport master (
    output req_valid, req_op, req_a, req_b, req_lock, resp_ready, alu_result, alu_zero,
    input  req_ready, alu_op, alu_a, alu_b, resp_valid, resp_result, resp_zero, resp_err
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_lock, resp_ready, alu_result, alu_zero,
    output req_ready, alu_op, alu_a, alu_b, resp_valid, resp_result, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rtl/alu_share_arbiter_rr_arb2.sv - two-way round-robin grant with a force-to-requester-1 override
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       force_1,
  output logic       grant
);

  // Contention and the idle case both point at whoever did not win last.
  always_comb begin
    grant = ~last_grant;
    if (force_1)
      grant = REQ_PMP;
    else if (valid == 2'b01)
      grant = REQ_EX;
    else if (valid == 2'b10)
      grant = REQ_PMP;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between execute and PMP requesters, registered response
// Optional PMP lock for atomic TOR compare pairs: define ALU_ARB_LOCK_EN.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_arbiter_if.slave bus
);

  logic [0:0]      state;
  logic            owner;
  logic            last_grant;
  logic            lock;
  logic            grant;
  logic            can_accept;
  logic            accept;
  logic            any_valid;
  logic [1:0]      resp_valid_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            err_q;
  logic [OP_W-1:0] g_op;
  logic [XLEN-1:0] g_a;
  logic [XLEN-1:0] g_b;

  rr_arb2 u_arb (
    .valid      (bus.req_valid),
    .last_grant (last_grant),
    .force_1    (lock),
    .grant      (grant)
  );

  assign any_valid  = |bus.req_valid;
  assign can_accept = (state == IDLE) || bus.resp_ready[owner];
  assign accept     = bus.req_valid[grant] && can_accept;

  assign g_op = grant ? bus.req_op[2*OP_W-1:OP_W] : bus.req_op[OP_W-1:0];
  assign g_a  = grant ? bus.req_a[2*XLEN-1:XLEN]  : bus.req_a[XLEN-1:0];
  assign g_b  = grant ? bus.req_b[2*XLEN-1:XLEN]  : bus.req_b[XLEN-1:0];

  assign bus.req_ready   = can_accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.alu_op      = any_valid ? g_op : '0;
  assign bus.alu_a       = any_valid ? g_a  : '0;
  assign bus.alu_b       = any_valid ? g_b  : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_zero   = zero_q;
  assign bus.resp_err    = err_q;

`ifdef ALU_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock <= 1'b0;
    else if (accept && grant == REQ_PMP)
      lock <= bus.req_lock;
  end
`else
  logic unused_req_lock;
  assign unused_req_lock = bus.req_lock;
  assign lock            = 1'b0;
`endif

  // An accept in the consume cycle overwrites the held response directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= REQ_EX;
      last_grant   <= REQ_PMP;
      resp_valid_q <= 2'b00;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (accept) begin
      state        <= RESP;
      owner        <= grant;
      last_grant   <= grant;
      resp_valid_q <= grant ? 2'b10 : 2'b01;
      result_q     <= op_legal(g_op) ? bus.alu_result : '0;
      zero_q       <= op_legal(g_op) && bus.alu_zero;
      err_q        <= !op_legal(g_op);
    end else if (state == RESP && bus.resp_ready[owner]) begin
      state        <= IDLE;
      resp_valid_q <= 2'b00;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter (lock checks follow ALU_ARB_LOCK_EN)
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] res;
    logic        z;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arbiter_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

  alu_share_arbiter #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  exp_t        ex;
  logic [35:0] obs;
  int          total = 0;
  int          bad   = 0;

  // Reference ALU; illegal ops produce junk so the arbiter's masking is visible.
  always_comb begin
    logic [31:0] r;
    logic        legal;
    r     = 32'hDEAD_BEEF;
    legal = 1'b1;
    case (bus.alu_op)
      OP_AND:  r = bus.alu_a & bus.alu_b;
      OP_OR:   r = bus.alu_a | bus.alu_b;
      OP_ADD:  r = bus.alu_a + bus.alu_b;
      OP_SUB:  r = bus.alu_a - bus.alu_b;
      OP_SLT:  r = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_NOR:  r = ~(bus.alu_a | bus.alu_b);
      default: legal = 1'b0;
    endcase
    bus.alu_result = r;
    bus.alu_zero   = legal ? (r == 32'd0) : 1'b1;
  end

  always_comb obs = {bus.resp_valid, bus.resp_result, bus.resp_zero, bus.resp_err};

  task automatic set_req(input logic [1:0] v, input logic [3:0] op0, input logic [31:0] a0, b0,
                         input logic [3:0] op1, input logic [31:0] a1, b1);
    bus.req_valid = v;
    bus.req_op    = {op1, op0};
    bus.req_a     = {a1, a0};
    bus.req_b     = {b1, b0};
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.req_lock   = 1'b0;
    bus.resp_ready = 2'b00;
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req_lock   = 1'b0;
    bus.resp_ready = 2'b00;
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    #2;
    total++;
    if (obs !== 36'd0) begin bad++; $display("FAIL reset_in_reset got=%h want=0", obs); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs !== 36'd0) begin bad++; $display("FAIL reset_after_release got=%h want=0", obs); end
    total++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 68'd0) begin
      bad++; $display("FAIL reset_alu_idle got=%h/%h/%h want=0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    set_req(2'b11, OP_ADD, 32'd1, 32'd1, OP_SUB, 32'd2, 32'd1);
    #2;
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", bus.req_ready); end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    bus.resp_ready = 2'b11;
    set_req(2'b01, OP_ADD, 32'd5, 32'd7, OP_AND, 32'd0, 32'd0);
    #2;
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b want=01", bus.req_ready); end
    exp_q.push_back('{vld: 2'b01, res: 32'd12, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL add_resp got=%h want=%h", obs, ex); end
    @(posedge clk); #1;
    total++;
    if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL add_clear got=%b want=00", bus.resp_valid); end
  endtask

  task automatic test_alternate();
    logic       g;
    logic [1:0] gv;
    do_reset();
    bus.resp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      set_req(2'b11, OP_ADD, 32'(i), 32'd1, OP_SUB, 32'd100, 32'(i));
      #2;
      g  = (i % 2) == 1;
      gv = g ? 2'b10 : 2'b01;
      total++;
      if (bus.req_ready !== gv) begin bad++; $display("FAIL alt_ready[%0d] got=%b want=%b", i, bus.req_ready, gv); end
      exp_q.push_back('{vld: gv, res: g ? 32'(100 - i) : 32'(i + 1), z: 1'b0, e: 1'b0});
      @(posedge clk); #1;
      if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
      total++;
      if (obs !== ex) begin bad++; $display("FAIL alt_resp[%0d] got=%h want=%h", i, obs, ex); end
    end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    total++;
    if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL alt_clear got=%b want=00", bus.resp_valid); end
  endtask

  task automatic test_hold();
    bus.resp_ready = 2'b01;
    set_req(2'b10, OP_AND, 32'd0, 32'd0, OP_SUB, 32'd9, 32'd9);
    #2;
    total++;
    if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL hold_ready got=%b want=10", bus.req_ready); end
    exp_q.push_back('{vld: 2'b10, res: 32'd0, z: 1'b1, e: 1'b0});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    set_req(2'b01, OP_OR, 32'd1, 32'd2, OP_AND, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs !== ex) begin bad++; $display("FAIL hold_resp[%0d] got=%h want=%h", i, obs, ex); end
      #2;
      total++;
      if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL hold_busy[%0d] got=%b want=00", i, bus.req_ready); end
      @(posedge clk); #1;
    end
    total++;
    if (obs !== ex) begin bad++; $display("FAIL hold_resp_last got=%h want=%h", obs, ex); end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    bus.resp_ready = 2'b10;
    @(posedge clk); #1;
    total++;
    if (bus.resp_valid !== 2'b00) begin bad++; $display("FAIL hold_release got=%b want=00", bus.resp_valid); end
  endtask

  task automatic test_illegal();
    bus.resp_ready = 2'b11;
    set_req(2'b01, 4'b1010, 32'd3, 32'd4, OP_AND, 32'd0, 32'd0);
    #2;
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL illegal_ready got=%b want=01", bus.req_ready); end
    exp_q.push_back('{vld: 2'b01, res: 32'd0, z: 1'b0, e: 1'b1});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL illegal_resp got=%h want=%h", obs, ex); end
    set_req(2'b01, OP_SLT, 32'hFFFF_FFFF, 32'd1, OP_AND, 32'd0, 32'd0);
    #2;
    exp_q.push_back('{vld: 2'b01, res: 32'd1, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL slt_resp got=%h want=%h", obs, ex); end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    bus.resp_ready = 2'b00;
    set_req(2'b10, OP_AND, 32'd0, 32'd0, OP_SUB, 32'd5, 32'd3);
    #2;
    exp_q.push_back('{vld: 2'b10, res: 32'd2, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL areset_pending got=%h want=%h", obs, ex); end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 36'd0) begin bad++; $display("FAIL areset_async got=%h want=0", obs); end
    #2 rst_n = 1'b1;
    #1;
    bus.resp_ready = 2'b11;
    set_req(2'b11, OP_ADD, 32'd1, 32'd2, OP_SUB, 32'd5, 32'd5);
    #1;
    total++;
    if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL areset_first_grant got=%b want=01", bus.req_ready); end
    exp_q.push_back('{vld: 2'b01, res: 32'd3, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL areset_resp got=%h want=%h", obs, ex); end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    logic [3:0] grant_tbl;
    logic       g;
    logic [1:0] gv;
`ifdef ALU_ARB_LOCK_EN
    grant_tbl = 4'b0111;
`else
    grant_tbl = 4'b1010;
`endif
    do_reset();
    bus.resp_ready = 2'b11;
    bus.req_lock   = 1'b1;
    set_req(2'b10, OP_ADD, 32'd0, 32'd0, OP_SUB, 32'd2, 32'd1);
    #2;
    total++;
    if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL lock_first got=%b want=10", bus.req_ready); end
    exp_q.push_back('{vld: 2'b10, res: 32'd1, z: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
    total++;
    if (obs !== ex) begin bad++; $display("FAIL lock_first_resp got=%h want=%h", obs, ex); end
    for (int i = 0; i < 4; i++) begin
      bus.req_lock = (i < 2);
      set_req(2'b11, OP_ADD, 32'(i), 32'd1, OP_SUB, 32'd20, 32'(i));
      #2;
      g  = grant_tbl[i];
      gv = g ? 2'b10 : 2'b01;
      total++;
      if (bus.req_ready !== gv) begin bad++; $display("FAIL lock_ready[%0d] got=%b want=%b", i, bus.req_ready, gv); end
      exp_q.push_back('{vld: gv, res: g ? 32'(20 - i) : 32'(i + 1), z: 1'b0, e: 1'b0});
      @(posedge clk); #1;
      if (exp_q.size() != 0) ex = exp_q.pop_front(); else ex = 'x;
      total++;
      if (obs !== ex) begin bad++; $display("FAIL lock_resp[%0d] got=%h want=%h", i, obs, ex); end
    end
    set_req(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0);
    bus.req_lock = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alternate();
    test_hold();
    test_illegal();
    test_async_reset();
    test_lock();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
